// File: rtl/ibex_prefetch_queue.sv
// ---------------------------------------------------------------------------
// ibex_prefetch_queue
//
// Instruction prefetch queue between the IF-stage control and the
// instruction-side bus. It issues word-aligned fetches with up to
// MAX_OUTSTANDING granted-but-unanswered requests and buffers responses in a
// DEPTH-entry FIFO. A branch flushes the FIFO, and any response still in
// flight for the old stream is counted as "discard" and dropped on arrival.
// An entry tagged with a bus or PMP error stops further fetching until the
// next branch.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   req_i              fetch enable (low stops new requests)
//   branch_i           redirect fetch to branch_addr_i (bit 0 ignored)
//   ready_i            consumer pops the head when valid_o & ready_i
//   valid_o            head entry available
//   rdata_o            head data; upper halfword moved down when addr_o[1]=1
//   addr_o             head address (halfword aligned)
//   err_o              head entry carries a fetch error
//   count_o            FIFO occupancy
//   instr_req_o        bus request (held stable until granted)
//   instr_addr_o       bus address, bits [1:0] always 0
//   instr_gnt_i        bus grant
//   instr_rvalid_i     bus response valid (responses return in order)
//   instr_rdata_i      bus response data
//   instr_err_i        bus response error
//   instr_pmp_err_i    PMP fault for the presented address, sampled at grant
//   busy_o             request raised or any request outstanding
// ---------------------------------------------------------------------------
module ibex_prefetch_queue #(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       req_i,
  input  logic                       branch_i,
  input  logic [31:0]                branch_addr_i,
  input  logic                       ready_i,
  output logic                       valid_o,
  output logic [31:0]                rdata_o,
  output logic [31:0]                addr_o,
  output logic                       err_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       instr_req_o,
  output logic [31:0]                instr_addr_o,
  input  logic                       instr_gnt_i,
  input  logic                       instr_rvalid_i,
  input  logic [31:0]                instr_rdata_i,
  input  logic                       instr_err_i,
  input  logic                       instr_pmp_err_i,
  output logic                       busy_o
);

  // Counter width (0..DEPTH), FIFO pointer width, PMP-flag pointer width.
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  // Width for the credit sum of three counters, each at most DEPTH.
  localparam int SW = CW + 2;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic          r_idle;
  logic          r_stopped;
  logic [31:0]   r_fetch_addr;
  logic [31:0]   r_head_addr;

  // A raised but not yet granted request is held here so that address and
  // request stay stable regardless of req_i, credit or branches.
  logic          r_pend;
  logic          r_pend_stale;
  logic [31:0]   r_pend_addr;

  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;
  logic [CW-1:0] r_count;

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [31:0]   r_fifo_data [DEPTH];
  logic          r_fifo_err  [DEPTH];

  logic          r_pmp_q [MAX_OUTSTANDING];
  logic [PW-1:0] r_pmp_wr;
  logic [PW-1:0] r_pmp_rd;

  // -------------------------------------------------------------------------
  // Pointer helpers (wrap explicitly so non-power-of-two sizes work)
  // -------------------------------------------------------------------------
  function automatic logic [AW-1:0] f_fifo_inc(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) begin
      return '0;
    end
    return p + AW'(1);
  endfunction

  function automatic logic [PW-1:0] f_pmp_inc(input logic [PW-1:0] p);
    if (p == PW'(MAX_OUTSTANDING - 1)) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  // -------------------------------------------------------------------------
  // Request side
  // -------------------------------------------------------------------------
  logic [SW-1:0] w_credit_sum;
  logic          w_new_req;
  logic          w_req;
  logic [31:0]   w_req_addr;
  logic          w_gnt;
  logic          w_gnt_stale;

  // Discarded responses are counted on top of outstanding ones so a freshly
  // redirected stream cannot overrun the FIFO while stale data drains.
  assign w_credit_sum = SW'(r_outstanding) + SW'(r_count) + SW'(r_discard);

  assign w_new_req = req_i & ~r_idle & ~r_stopped
                   & (w_credit_sum < SW'(DEPTH))
                   & (r_outstanding < CW'(MAX_OUTSTANDING));

  assign w_req       = r_pend | w_new_req;
  assign w_req_addr  = r_pend ? r_pend_addr : r_fetch_addr;
  assign w_gnt       = w_req & instr_gnt_i;
  // A held request that survived a branch belongs to the old stream.
  assign w_gnt_stale = w_gnt & r_pend & r_pend_stale;

  assign instr_req_o  = w_req;
  assign instr_addr_o = w_req_addr;

  // -------------------------------------------------------------------------
  // Response side
  // -------------------------------------------------------------------------
  logic          w_rsp_pmp;
  logic          w_rsp_drop;
  logic          w_push;
  logic          w_push_err;
  logic          w_pop;
  logic [CW-1:0] w_out_next;
  logic [CW-1:0] w_discard_next;
  logic [CW-1:0] w_count_next;

  assign w_rsp_pmp  = r_pmp_q[r_pmp_rd];
  assign w_rsp_drop = instr_rvalid_i & (r_discard != '0);
  // Responses in a branch cycle are dropped; the branch also flushes.
  assign w_push     = instr_rvalid_i & ~branch_i & (r_discard == '0);
  assign w_push_err = instr_err_i | w_rsp_pmp;
  // Branch wins over a simultaneous pop.
  assign w_pop      = (r_count != '0) & ready_i & ~branch_i;

  assign w_out_next = r_outstanding + CW'(w_gnt) - CW'(instr_rvalid_i);

  // On a branch every request still unanswered after this cycle is stale,
  // including one granted in this very cycle.
  assign w_discard_next = branch_i ? w_out_next
                        : (r_discard + CW'(w_gnt_stale) - CW'(w_rsp_drop));

  assign w_count_next = branch_i ? '0
                      : (r_count + CW'(w_push) - CW'(w_pop));

  // -------------------------------------------------------------------------
  // Control registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_idle        <= 1'b1;
      r_stopped     <= 1'b0;
      r_fetch_addr  <= '0;
      r_head_addr   <= '0;
      r_pend        <= 1'b0;
      r_pend_stale  <= 1'b0;
      r_pend_addr   <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_pmp_wr      <= '0;
      r_pmp_rd      <= '0;
    end else begin
      r_outstanding <= w_out_next;
      r_discard     <= w_discard_next;
      r_count       <= w_count_next;

      // Held request bookkeeping.
      if (w_req && !instr_gnt_i) begin
        r_pend       <= 1'b1;
        r_pend_addr  <= w_req_addr;
        r_pend_stale <= (r_pend & r_pend_stale) | branch_i;
      end else begin
        r_pend       <= 1'b0;
        r_pend_stale <= 1'b0;
      end

      // PMP flag queue tracks every granted request, stale or not.
      if (w_gnt) begin
        r_pmp_wr <= f_pmp_inc(r_pmp_wr);
      end
      if (instr_rvalid_i) begin
        r_pmp_rd <= f_pmp_inc(r_pmp_rd);
      end

      if (branch_i) begin
        r_idle       <= 1'b0;
        r_stopped    <= 1'b0;
        r_fetch_addr <= {branch_addr_i[31:2], 2'b00};
        r_head_addr  <= {branch_addr_i[31:1], 1'b0};
        r_rd_ptr     <= r_wr_ptr;
      end else begin
        if (w_gnt && !w_gnt_stale) begin
          r_fetch_addr <= r_fetch_addr + 32'd4;
        end
        if (w_push) begin
          r_wr_ptr <= f_fifo_inc(r_wr_ptr);
          if (w_push_err) begin
            r_stopped <= 1'b1;
          end
        end
        if (w_pop) begin
          r_rd_ptr    <= f_fifo_inc(r_rd_ptr);
          r_head_addr <= {r_head_addr[31:2] + 30'd1, 2'b00};
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // FIFO storage and PMP flag storage
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_fifo
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_fifo_data[gi] <= '0;
          r_fifo_err[gi]  <= 1'b0;
        end else if (w_push && (r_wr_ptr == AW'(gi))) begin
          r_fifo_data[gi] <= instr_rdata_i;
          r_fifo_err[gi]  <= w_push_err;
        end
      end
    end

    for (gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_pmp
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_pmp_q[gi] <= 1'b0;
        end else if (w_gnt && (r_pmp_wr == PW'(gi))) begin
          r_pmp_q[gi] <= instr_pmp_err_i;
        end
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  logic [31:0] w_head_data;
  logic        w_unused_addr_bit;

  assign w_head_data       = r_fifo_data[r_rd_ptr];
  // Bit 0 of the branch target never matters: instructions are halfwords.
  assign w_unused_addr_bit = branch_addr_i[0];

  assign valid_o = (r_count != '0);
  assign rdata_o = r_head_addr[1] ? {16'h0000, w_head_data[31:16]} : w_head_data;
  assign addr_o  = r_head_addr;
  assign err_o   = valid_o & r_fifo_err[r_rd_ptr];
  assign count_o = r_count;
  assign busy_o  = w_req | (r_outstanding != '0);

endmodule
